// File: rtl/sine_voice_scheduler_if.sv
// Mixed-sample output stream: valid/ready handshake carrying one signed sample.
interface sine_voice_scheduler_if #(
    parameter int SAMPLE_W = 24
);
    logic                valid;
    logic                ready;
    logic [SAMPLE_W-1:0] sample;

    modport master (output valid, output sample, input ready);
    modport slave  (input valid, input sample, output ready);
endinterface

// File: rtl/sine_voice_scheduler.sv
// Shares one 1-cycle-latency sine LUT among NUM_VOICES phase accumulators.
// Each sample tick scans every voice, mixes the LUT words and offers the
// average on a valid/ready stream; ticks that land on a pending sample are
// dropped and flagged on overrun_o.
module sine_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 32,
    parameter int ADDR_W     = 5,
    parameter int SAMPLE_W   = 24,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          cfg_valid_i,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice_i,
    input  logic [PHASE_W-1:0]            cfg_step_i,
    input  logic                          cfg_enable_i,
    output logic [ADDR_W-1:0]             lut_addr_o,
    input  logic [SAMPLE_W-1:0]           lut_data_i,
    sine_voice_scheduler_if.master        out_if,
    output logic                          overrun_o
);
    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + VW;
    localparam int CNT_W = $clog2(SAMPLE_DIV);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, HOLD} state_t;

    state_t                                 state_q, state_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [VW-1:0]                          k_q, k_d;
    logic [NUM_VOICES-1:0][PHASE_W-1:0]     phase_q, phase_d;
    logic [NUM_VOICES-1:0][PHASE_W-1:0]     step_sh_q, step_sh_d;
    logic [NUM_VOICES-1:0][PHASE_W-1:0]     step_q, step_d;
    logic [NUM_VOICES-1:0]                  en_sh_q, en_sh_d;
    logic [NUM_VOICES-1:0]                  en_q, en_d;
    logic signed [ACC_W-1:0]                acc_q, acc_d;
    logic                                   rd_vld_q, rd_vld_d;
    logic                                   rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]                      addr_q, addr_d;
    logic                                   valid_q, valid_d;
    logic [SAMPLE_W-1:0]                    sample_q, sample_d;
    logic                                   overrun_q, overrun_d;

    logic                                   tick;
    logic [VW-1:0]                          k_nxt;
    logic signed [ACC_W-1:0]                lut_ext;
    logic signed [ACC_W-1:0]                acc_shr;

    // Next-state: tick counter, shadow config, scan sequencing and mixing.
    always_comb begin
        tick      = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        k_nxt     = k_q + 1'b1;
        lut_ext   = ACC_W'($signed(lut_data_i));
        acc_shr   = '0;
        state_d   = state_q;
        k_d       = k_q;
        phase_d   = phase_q;
        step_sh_d = step_sh_q;
        en_sh_d   = en_sh_q;
        step_d    = step_q;
        en_d      = en_q;
        acc_d     = acc_q;
        rd_vld_d  = 1'b0;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        valid_d   = valid_q;
        sample_d  = sample_q;
        // A tick that finds a sample still pending is dropped.
        overrun_d = tick & valid_q;

        if (cfg_valid_i) begin
            step_sh_d[cfg_voice_i] = cfg_step_i;
            en_sh_d[cfg_voice_i]   = cfg_enable_i;
        end

        // LUT word for the voice issued last cycle; disabled voices add 0.
        if (rd_vld_q && rd_en_q)
            acc_d = acc_q + lut_ext;

        case (state_q)
            IDLE: begin
                if (tick && !valid_q) begin
                    state_d = SCAN;
                    step_d  = step_sh_q;
                    en_d    = en_sh_q;
                    acc_d   = '0;
                    k_d     = '0;
                    addr_d  = phase_q[0][PHASE_W-1 -: ADDR_W];
                end
            end
            SCAN: begin
                // addr_q already holds voice k's address; advance its phase.
                rd_vld_d     = 1'b1;
                rd_en_d      = en_q[k_q];
                phase_d[k_q] = en_q[k_q] ? phase_q[k_q] + step_q[k_q] : '0;
                if (k_q == VW'(NUM_VOICES - 1)) begin
                    state_d = DRAIN;
                end else begin
                    k_d    = k_nxt;
                    addr_d = phase_q[k_nxt][PHASE_W-1 -: ADDR_W];
                end
            end
            DRAIN: begin
                acc_shr  = acc_d >>> VW;
                sample_d = acc_shr[SAMPLE_W-1:0];
                valid_d  = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                if (valid_q && out_if.ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any scan in progress.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            phase_q   <= '0;
            step_sh_q <= '0;
            en_sh_q   <= '0;
            step_q    <= '0;
            en_q      <= '0;
            acc_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            sample_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            phase_q   <= phase_d;
            step_sh_q <= step_sh_d;
            en_sh_q   <= en_sh_d;
            step_q    <= step_d;
            en_q      <= en_d;
            acc_q     <= acc_d;
            rd_vld_q  <= rd_vld_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
        end
    end

    assign lut_addr_o    = addr_q;
    assign out_if.valid  = valid_q;
    assign out_if.sample = sample_q;
    assign overrun_o     = overrun_q;
endmodule
